// File: rtl/cpu_memory_stage.sv
// Memory pipeline stage: routes ALU results to Writeback and runs data-memory requests.
// Latency: 1 cycle for ALU ops; 1 cycle plus the memory wait for loads and stores.
// Backpressure: stallM holds the upstream stages while a request is open. New work is not taken on the completion edge.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   validE, aluOutputE, writeDataE,
//   memReadE, memWriteE, regWriteE,
//   destRegE                            instruction from Execute
//   memAddr, memWData, memRead,
//   memWrite / memRData, memReady       data-memory request / response
//   resultM, destRegM, regWriteM,
//   validM                              to Writeback
//   forwardM                            forwarding value back to Execute
//   stallM                              upstream hold
//   memErrorM                           one-cycle timeout pulse
//
// Optional feature: define MEM_TIMEOUT_EN to abort a request that has waited
// TIMEOUT cycles in ACCESS. Without it, ACCESS waits for memReady indefinitely.

module cpu_memory_stage #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    validE,
  input  logic [WIDTH-1:0]        aluOutputE,
  input  logic [WIDTH-1:0]        writeDataE,
  input  logic                    memReadE,
  input  logic                    memWriteE,
  input  logic                    regWriteE,
  input  logic [ADDRESSWIDTH-1:0] destRegE,
  output logic [WIDTH-1:0]        memAddr,
  output logic [WIDTH-1:0]        memWData,
  output logic                    memRead,
  output logic                    memWrite,
  input  logic [WIDTH-1:0]        memRData,
  input  logic                    memReady,
  output logic [WIDTH-1:0]        resultM,
  output logic [ADDRESSWIDTH-1:0] destRegM,
  output logic                    regWriteM,
  output logic                    validM,
  output logic [WIDTH-1:0]        forwardM,
  output logic                    stallM,
  output logic                    memErrorM
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state;
  state_t stateNext;

  // Writeback fields of the memory op in flight. They are published only on
  // completion, so destRegM and regWriteM hold their values during the bubble.
  logic [ADDRESSWIDTH-1:0] pendDest;
  logic                    pendRegWrite;

  logic accept;
  logic isMemOp;
  logic timeoutHit;

  assign accept   = (state == IDLE) && validE;
  assign isMemOp  = memReadE || memWriteE;
  assign stallM   = (state == ACCESS);
  assign forwardM = resultM;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  // The counter holds the number of ACCESS cycles already completed. The
  // TIMEOUT-th cycle is therefore the one where it reads TIMEOUT-1.
  logic [CW-1:0] timeoutCnt;

  assign timeoutHit = (state == ACCESS) && !memReady && (timeoutCnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeoutCnt <= '0;
    end else if (accept && isMemOp) begin
      timeoutCnt <= '0;
    end else if (state == ACCESS) begin
      timeoutCnt <= timeoutCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memErrorM <= 1'b0;
    end else begin
      memErrorM <= timeoutHit;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign memErrorM  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (validE && isMemOp) stateNext = ACCESS;
      ACCESS:  if (memReady || timeoutHit) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultM      <= '0;
      destRegM     <= '0;
      regWriteM    <= 1'b0;
      validM       <= 1'b0;
      memAddr      <= '0;
      memWData     <= '0;
      memRead      <= 1'b0;
      memWrite     <= 1'b0;
      pendDest     <= '0;
      pendRegWrite <= 1'b0;
    end else begin
      validM <= 1'b0;
      if (accept) begin
        if (isMemOp) begin
          memAddr      <= aluOutputE;
          memWData     <= writeDataE;
          // Read and write together is treated as a write.
          memWrite     <= memWriteE;
          memRead      <= memReadE && !memWriteE;
          pendDest     <= destRegE;
          pendRegWrite <= regWriteE && !memWriteE;
        end else begin
          resultM   <= aluOutputE;
          destRegM  <= destRegE;
          regWriteM <= regWriteE;
          validM    <= 1'b1;
        end
      end else if (state == ACCESS) begin
        if (memReady) begin
          // A store reports its address as its result.
          resultM   <= memRead ? memRData : memAddr;
          destRegM  <= pendDest;
          regWriteM <= pendRegWrite;
          validM    <= 1'b1;
          memRead   <= 1'b0;
          memWrite  <= 1'b0;
        end else if (timeoutHit) begin
          destRegM  <= pendDest;
          regWriteM <= 1'b0;
          validM    <= 1'b1;
          memRead   <= 1'b0;
          memWrite  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_memory_stage.sv
// Directed bench for cpu_memory_stage: ALU op, loads, stores, back-to-back
// loads, reset during a pending load and, when MEM_TIMEOUT_EN is defined,
// the timeout abort.

module tb_cpu_memory_stage;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          validE;
  logic [W-1:0]  aluOutputE;
  logic [W-1:0]  writeDataE;
  logic          memReadE;
  logic          memWriteE;
  logic          regWriteE;
  logic [AW-1:0] destRegE;
  logic [W-1:0]  memAddr;
  logic [W-1:0]  memWData;
  logic          memRead;
  logic          memWrite;
  logic [W-1:0]  memRData;
  logic          memReady;
  logic [W-1:0]  resultM;
  logic [AW-1:0] destRegM;
  logic          regWriteM;
  logic          validM;
  logic [W-1:0]  forwardM;
  logic          stallM;
  logic          memErrorM;

  int checkCount = 0;
  int errorCount = 0;

  cpu_memory_stage #(.WIDTH(W), .ADDRESSWIDTH(AW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .validE(validE), .aluOutputE(aluOutputE), .writeDataE(writeDataE),
    .memReadE(memReadE), .memWriteE(memWriteE), .regWriteE(regWriteE),
    .destRegE(destRegE),
    .memAddr(memAddr), .memWData(memWData), .memRead(memRead), .memWrite(memWrite),
    .memRData(memRData), .memReady(memReady),
    .resultM(resultM), .destRegM(destRegM), .regWriteM(regWriteM), .validM(validM),
    .forwardM(forwardM), .stallM(stallM), .memErrorM(memErrorM)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present an instruction; applied at the falling edge.
  task automatic issue(input logic rd, input logic wr, input logic rw,
                       input logic [W-1:0] alu, input logic [W-1:0] wd,
                       input logic [AW-1:0] dst);
    validE = 1'b1; memReadE = rd; memWriteE = wr; regWriteE = rw;
    aluOutputE = alu; writeDataE = wd; destRegE = dst;
  endtask

  task automatic edgeSample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; validE = 1'b0; memReadE = 1'b0; memWriteE = 1'b0; regWriteE = 1'b0;
    aluOutputE = '0; writeDataE = '0; destRegE = '0; memRData = '0; memReady = 1'b0;

    // Reset state
    #2;
    checkVal("rst_validM",   validM,    0);
    checkVal("rst_resultM",  resultM,   0);
    checkVal("rst_destRegM", destRegM,  0);
    checkVal("rst_memRead",  memRead,   0);
    checkVal("rst_stallM",   stallM,    0);
    checkVal("rst_memError", memErrorM, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // ALU op: one-cycle latency
    @(negedge clk);
    issue(0, 0, 1, 16'd8, 16'd0, 4'd1);
    edgeSample();
    checkVal("alu_validM",   validM,    1);
    checkVal("alu_resultM",  resultM,   8);
    checkVal("alu_forwardM", forwardM,  8);
    checkVal("alu_destRegM", destRegM,  1);
    checkVal("alu_regWrite", regWriteM, 1);
    checkVal("alu_stallM",   stallM,    0);
    @(negedge clk);
    validE = 1'b0;
    edgeSample();
    checkVal("alu_pulse_end", validM,  0);
    checkVal("alu_hold",      resultM, 8);

    // Load, ready on the third ACCESS cycle
    @(negedge clk);
    issue(1, 0, 1, 16'h0010, 16'h0, 4'd2);
    memRData = 16'h00AB;
    edgeSample();
    checkVal("ld_bubble", validM, 0);
    @(negedge clk);
    validE = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      checkVal("ld_stallM",  stallM,  1);
      checkVal("ld_memRead", memRead, 1);
      checkVal("ld_memAddr", memAddr, 16'h0010);
      checkVal("ld_waitValid", validM, 0);
      memReady = (i == 3);
      if (i < 3) @(negedge clk);
    end
    edgeSample();
    checkVal("ld_validM",   validM,   1);
    checkVal("ld_resultM",  resultM,  16'h00AB);
    checkVal("ld_destRegM", destRegM, 2);
    checkVal("ld_regWrite", regWriteM, 1);
    checkVal("ld_reqDrop",  memRead,  0);
    checkVal("ld_stallEnd", stallM,   0);

    // Store with memReady already high (ignored in IDLE, completes after one ACCESS cycle)
    @(negedge clk);
    issue(0, 1, 1, 16'h0020, 16'h1234, 4'd5);
    edgeSample();
    checkVal("st_memWrite", memWrite, 1);
    checkVal("st_memAddr",  memAddr,  16'h0020);
    checkVal("st_memWData", memWData, 16'h1234);
    checkVal("st_bubble",   validM,   0);
    checkVal("st_stallM",   stallM,   1);
    @(negedge clk);
    validE = 1'b0;
    edgeSample();
    checkVal("st_validM",   validM,    1);
    checkVal("st_regWrite", regWriteM, 0);
    checkVal("st_resultM",  resultM,   16'h0020);
    checkVal("st_reqDrop",  memWrite,  0);

    // Read and write together is a write
    @(negedge clk);
    memReady = 1'b0;
    issue(1, 1, 1, 16'h0024, 16'h5555, 4'd6);
    edgeSample();
    checkVal("rw_memWrite", memWrite, 1);
    checkVal("rw_memRead",  memRead,  0);
    @(negedge clk);
    validE = 1'b0; memReady = 1'b1;
    edgeSample();
    checkVal("rw_regWrite", regWriteM, 0);
    checkVal("rw_resultM",  resultM,   16'h0024);

    // Back-to-back loads: second is held until after the first completes
    @(negedge clk);
    memReady = 1'b0; memRData = 16'h0011;
    issue(1, 0, 1, 16'h0030, 16'h0, 4'd3);
    edgeSample();
    @(negedge clk);
    issue(1, 0, 1, 16'h0040, 16'h0, 4'd4);
    memReady = 1'b1;
    edgeSample();
    checkVal("b2b_first_valid", validM,   1);
    checkVal("b2b_first_data",  resultM,  16'h0011);
    checkVal("b2b_first_dest",  destRegM, 3);
    checkVal("b2b_no_accept",   stallM,   0);
    @(negedge clk);
    memReady = 1'b0; memRData = 16'h0022;
    edgeSample();
    checkVal("b2b_second_bubble", validM,  0);
    checkVal("b2b_second_stall",  stallM,  1);
    checkVal("b2b_second_addr",   memAddr, 16'h0040);
    @(negedge clk);
    validE = 1'b0; memReady = 1'b1;
    edgeSample();
    checkVal("b2b_second_valid", validM,   1);
    checkVal("b2b_second_data",  resultM,  16'h0022);
    checkVal("b2b_second_dest",  destRegM, 4);
    @(negedge clk);
    memReady = 1'b0;
    edgeSample();
    checkVal("b2b_single_pulse", validM, 0);

    // Reset on the second wait cycle of a load
    @(negedge clk);
    issue(1, 0, 1, 16'h0050, 16'h0, 4'd7);
    edgeSample();
    @(negedge clk);
    validE = 1'b0;
    edgeSample();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkVal("rst_mid_memRead", memRead, 0);
    checkVal("rst_mid_validM",  validM,  0);
    checkVal("rst_mid_stallM",  stallM,  0);
    @(negedge clk);
    rst_n = 1'b1;
    memReady = 1'b1;
    edgeSample();
    checkVal("rst_no_pulse", validM, 0);
    @(negedge clk);
    memReady = 1'b0;
    issue(0, 0, 1, 16'd5, 16'd0, 4'd9);
    edgeSample();
    checkVal("resume_valid",  validM,  1);
    checkVal("resume_result", resultM, 5);
    @(negedge clk);
    validE = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // Timeout abort after four ACCESS cycles with memReady low
    @(negedge clk);
    issue(1, 0, 1, 16'h0060, 16'h0, 4'd8);
    edgeSample();
    @(negedge clk);
    validE = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      edgeSample();
      checkVal("to_waiting", stallM, 1);
      checkVal("to_noError", memErrorM, 0);
    end
    edgeSample();
    checkVal("to_memError", memErrorM, 1);
    checkVal("to_validM",   validM,    1);
    checkVal("to_regWrite", regWriteM, 0);
    checkVal("to_stallM",   stallM,    0);
    checkVal("to_reqDrop",  memRead,   0);
    edgeSample();
    checkVal("to_pulse_end", memErrorM, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
